// File: rtl/cci_test_csr_pkg.sv
// cci_test_csr_pkg: shared types and word-address map
// for the CCI test CSR manager.
package cci_test_csr_pkg;

  typedef logic [8:0]  t_mmio_tid;
  typedef logic [15:0] t_mmio_addr;

  localparam t_mmio_addr DFH_WORD      = 16'h0000;
  localparam t_mmio_addr AFU_ID_L_WORD = 16'h0002;
  localparam t_mmio_addr AFU_ID_H_WORD = 16'h0004;
  localparam t_mmio_addr SCRATCH_WORD  = 16'h0006;

  localparam int NUM_CSRS = 8;

  typedef struct packed {
    logic        en;
    logic [63:0] data;
  } t_cpu_wr_csr;

  typedef struct packed {
    logic [63:0] data;
  } t_cpu_rd_csr;

endpackage

// File: rtl/cci_test_csr_if.sv
// test_csrs: bundle between the CSR manager and the
// test engine (write strobes out, live values back).
interface test_csrs;
  import cci_test_csr_pkg::*;

  t_cpu_wr_csr cpu_wr_csrs [0:NUM_CSRS-1];
  t_cpu_rd_csr cpu_rd_csrs [0:NUM_CSRS-1];

  modport csr (
    output cpu_wr_csrs,
    input  cpu_rd_csrs
  );

endinterface

// File: rtl/cci_test_csr_rd_pipe.sv
// cci_test_csr_rd_pipe: two-stage MMIO read path.
// Stage 1 holds the request, stage 2 the muxed data.
module cci_test_csr_rd_pipe
  import cci_test_csr_pkg::*;
#(
  parameter logic [63:0] AFU_DFH       = 64'h0,
  parameter logic [63:0] AFU_ID_L      = 64'h0,
  parameter logic [63:0] AFU_ID_H      = 64'h0,
  parameter t_mmio_addr  CSR_BASE_WORD = 16'h0040,
  parameter bit          SCRATCH_EN    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_valid,
  input  t_mmio_addr  rd_addr,
  input  t_mmio_tid   rd_tid,
  input  logic        rd_len64,
  input  logic [63:0] csr_data [0:NUM_CSRS-1],
  input  logic [63:0] scratch,
  output logic        rsp_valid,
  output t_mmio_tid   rsp_tid,
  output logic [63:0] rsp_data
);

  logic       s1_valid;
  t_mmio_addr s1_addr;
  t_mmio_tid  s1_tid;
  logic       s1_len64;

  t_mmio_addr  ev_addr;
  t_mmio_addr  csr_off;
  logic        csr_hit;
  logic        scr_hit;
  logic [63:0] qword;
  logic [63:0] rd_mux;

  // Stage 1: capture the request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_tid   <= '0;
      s1_len64 <= 1'b0;
    end else begin
      s1_valid <= rd_valid;
      s1_addr  <= rd_addr;
      s1_tid   <= rd_tid;
      s1_len64 <= rd_len64;
    end
  end

  // Decode the 64-bit word and pick the requested size.
  always_comb begin
    ev_addr = {s1_addr[15:1], 1'b0};
    csr_off = ev_addr - CSR_BASE_WORD;
    csr_hit = (csr_off[15:4] == '0);
    scr_hit = SCRATCH_EN && (ev_addr == SCRATCH_WORD);
    qword   = '0;
    unique case (1'b1)
      (ev_addr == DFH_WORD):      qword = AFU_DFH;
      (ev_addr == AFU_ID_L_WORD): qword = AFU_ID_L;
      (ev_addr == AFU_ID_H_WORD): qword = AFU_ID_H;
      scr_hit:                    qword = scratch;
      csr_hit:  qword = csr_data[csr_off[3:1]];
      default:                    qword = '0;
    endcase
    if (s1_len64) begin
      rd_mux = s1_addr[0] ? 64'h0 : qword;
    end else begin
      rd_mux = {32'h0, s1_addr[0] ? qword[63:32]
                                  : qword[31:0]};
    end
  end

  // Stage 2: register the response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_tid   <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_tid  <= s1_tid;
        rsp_data <= rd_mux;
      end
    end
  end

endmodule

// File: rtl/cci_test_csr_mgr.sv
// cci_test_csr_mgr: MMIO front end for the test CSRs.
// CCI_TEST_CSR_SCRATCH_EN adds a scratch reg at word 6.
module cci_test_csr_mgr
  import cci_test_csr_pkg::*;
#(
  parameter logic [63:0] AFU_DFH = 64'h1000_0100_0000_0000,
  parameter logic [63:0] AFU_ID_L      = 64'h0,
  parameter logic [63:0] AFU_ID_H      = 64'h0,
  parameter t_mmio_addr  CSR_BASE_WORD = 16'h0040
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mmio_wr_valid,
  input  logic        mmio_rd_valid,
  input  t_mmio_addr  mmio_addr,
  input  logic        mmio_len64,
  input  t_mmio_tid   mmio_tid,
  input  logic [63:0] mmio_wr_data,
  output logic        mmio_rsp_valid,
  output t_mmio_tid   mmio_rsp_tid,
  output logic [63:0] mmio_rsp_data,
  test_csrs.csr       csrs
);

  t_cpu_wr_csr wr_q [0:NUM_CSRS-1];
  logic [63:0] rd_data [0:NUM_CSRS-1];
  logic [63:0] scratch;

  t_mmio_addr w_off;
  logic       wr_hit;
  logic [2:0] w_idx;

  // Only aligned 8-byte writes inside the CSR window count.
  always_comb begin
    w_off  = mmio_addr - CSR_BASE_WORD;
    wr_hit = mmio_wr_valid && mmio_len64 &&
             !mmio_addr[0] && (w_off[15:4] == '0);
    w_idx  = w_off[3:1];
  end

  // One-cycle enable pulse; data holds until rewritten.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CSRS; i++) begin
        wr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CSRS; i++) begin
        wr_q[i].en <= wr_hit && (w_idx == 3'(i));
        if (wr_hit && (w_idx == 3'(i))) begin
          wr_q[i].data <= mmio_wr_data;
        end
      end
    end
  end

  // Map the interface arrays to local ones.
  always_comb begin
    for (int i = 0; i < NUM_CSRS; i++) begin
      csrs.cpu_wr_csrs[i] = wr_q[i];
      rd_data[i] = csrs.cpu_rd_csrs[i].data;
    end
  end

`ifdef CCI_TEST_CSR_SCRATCH_EN
  localparam bit SCRATCH_EN = 1'b1;

  // Scratch register, 8-byte writes only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scratch <= '0;
    end else if (mmio_wr_valid && mmio_len64 &&
                 mmio_addr == SCRATCH_WORD) begin
      scratch <= mmio_wr_data;
    end
  end
`else
  localparam bit SCRATCH_EN = 1'b0;

  assign scratch = '0;
`endif

  cci_test_csr_rd_pipe #(
    .AFU_DFH       (AFU_DFH),
    .AFU_ID_L      (AFU_ID_L),
    .AFU_ID_H      (AFU_ID_H),
    .CSR_BASE_WORD (CSR_BASE_WORD),
    .SCRATCH_EN    (SCRATCH_EN)
  ) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .rd_valid  (mmio_rd_valid),
    .rd_addr   (mmio_addr),
    .rd_tid    (mmio_tid),
    .rd_len64  (mmio_len64),
    .csr_data  (rd_data),
    .scratch   (scratch),
    .rsp_valid (mmio_rsp_valid),
    .rsp_tid   (mmio_rsp_tid),
    .rsp_data  (mmio_rsp_data)
  );

endmodule

// File: doc/cci_test_csr_mgr.md
CCI_TEST_CSR_MGR -- requirements
Module: cci_test_csr_mgr

Interface
REQ-001 The block SHALL have one clock and asynchronous, active-high reset: parameters and ports are listed below.
REQ-002 AFU_DFH, 64'h1000_0100_0000_0000, value returned at DFH word 0.
REQ-003 AFU_ID_L, 64'h0, low AFU GUID half, word 2.
REQ-004 AFU_ID_H, 64'h0, high AFU GUID half, word 4.
REQ-005 CSR_BASE_WORD, 16'h0040, 32-bit word address of test CSR 0 (byte 0x100).
REQ-006 clk  in  1  sole clock.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 mmio_wr_valid  in  1  MMIO write request strobe.
REQ-009 mmio_rd_valid  in  1  MMIO read request strobe.
REQ-010 mmio_addr  in  16  32-bit word address of request.
REQ-011 mmio_len64  in  1  1 = 8-byte access, 0 = 4-byte access.
REQ-012 mmio_tid  in  9  read transaction ID.
REQ-013 mmio_wr_data  in  64  write payload.
REQ-014 mmio_rsp_valid  out  1  read response strobe.
REQ-015 mmio_rsp_tid  out  9  echoed read TID.
REQ-016 mmio_rsp_data  out  64  read response data.
REQ-017 csrs  modport  test_csrs.csr  drives cpu_wr_csrs[0:7] and samples cpu_rd_csrs[0:7].

Function
REQ-018 Test CSR i (0..7) SHALL occupy word CSR_BASE_WORD + 2*i; 8-byte accesses require even word addresses.
REQ-019 An 8-byte write to test CSR i SHALL pulse cpu_wr_csrs[i].en for exactly one cycle, one cycle after mmio_wr_valid, with cpu_wr_csrs[i].data = mmio_wr_data.
REQ-020 cpu_wr_csrs[i].data SHALL hold its last written value until the next write to index i.
REQ-021 4-byte writes and writes to unmapped or odd addresses SHALL be silently ignored; no en pulse.
REQ-022 Every read SHALL produce exactly one response two cycles after mmio_rd_valid, with mmio_rsp_tid = mmio_tid: stage 1 registers addr/tid/len, stage 2 registers the muxed data.
REQ-023 Reads SHALL be accepted every cycle back-to-back with no backpressure; responses SHALL leave in request order.
REQ-024 8-byte reads SHALL return: word 0 AFU_DFH, word 2 AFU_ID_L, word 4 AFU_ID_H, test CSR i cpu_rd_csrs[i].data sampled in stage 1; unmapped addresses return 0.
REQ-025 4-byte reads SHALL return the addressed 32-bit half (even word low half, odd word high half) in data[31:0], with data[63:32] = 0.
REQ-026 Simultaneous mmio_wr_valid and mmio_rd_valid SHALL both be processed independently; a read of CSR i in the same cycle as a write to i returns cpu_rd_csrs[i], never the write data.

Reset
REQ-027 On reset assertion, mmio_rsp_valid, all en bits, pipeline valids and all cpu_wr_csrs data SHALL clear to 0 immediately; mmio_rsp_tid/data SHALL reset to 0.
REQ-028 Reads in flight at reset SHALL be dropped without a response; requests presented while reset is high SHALL be ignored.

Configuration
REQ-029 With CCI_TEST_CSR_SCRATCH_EN defined, a 64-bit scratch register at word 6 SHALL be read/write (reset 0, 8-byte writes only, 4-byte reads per REQ-025).
REQ-030 Without CCI_TEST_CSR_SCRATCH_EN, word 6 SHALL behave as unmapped (reads 0, writes ignored).

Structure
REQ-031 Package cci_test_csr_pkg SHALL hold the word-address constants (DFH, AFU_ID_L/H, scratch), t_mmio_tid (9 bits) and t_mmio_addr (16 bits).
REQ-032 The two-stage read path SHALL be a sub-module cci_test_csr_rd_pipe; write decode stays in the top module.

Verification
REQ-033 Write 64'hDEAD_BEEF_0123_4567 to word 16'h0046 (CSR 3), len64=1 -> csrs.cpu_wr_csrs[3].en high for one cycle at T+1 with that data; no other en.
REQ-034 Reads at words 0, 2, 4 with tids 1, 2, 3 on consecutive cycles -> three responses on consecutive cycles at T+2, tids 1, 2, 3, data AFU_DFH, AFU_ID_L, AFU_ID_H.
REQ-035 cpu_rd_csrs[7].data = 64'h1122_3344_5566_7788; 4-byte read at word 16'h004F -> rsp_data 64'h0000_0000_1122_3344.
REQ-036 4-byte write to word 16'h0040 and 8-byte write to word 16'h0041 -> no en pulse; 8-byte read of word 16'h0100 -> rsp_data 0.
REQ-037 Read issued, reset pulsed the next cycle -> no response; first read after reset answers normally; with CCI_TEST_CSR_SCRATCH_EN, write 64'h5A5A to word 6 then read -> 64'h5A5A, without macro -> 0.
